subtrator_completo: RTL and testbench

SUBTRATOR_COMPLETO -- requirements
Module: subtrator_completo

---
 rtl/subtrator_completo.sv | 100 ++++++++++
 tb/tb_subtrator_completo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/subtrator_completo.sv
`default_nettype none
// ============================================================================
//  Module      : subtrator_completo
//  Description : Registered ripple-borrow full subtractor of WIDTH bits.
//                Each cycle with in_valid high, s/cout load
//                (a - b - cin) mod 2^WIDTH and the final borrow; cycles
//                with in_valid low hold s/cout and drop out_valid.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand / difference width in bits (legal 1..64)
//  Ports
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous active-high reset
//    in_valid   in   1      qualifies a, b, cin this cycle
//    a          in   WIDTH  minuend (unsigned)
//    b          in   WIDTH  subtrahend (unsigned)
//    cin        in   1      borrow-in
//    s          out  WIDTH  registered difference
//    cout       out  1      registered borrow-out
//    out_valid  out  1      s/cout hold a result computed on the last edge
// ============================================================================

// ----------------------------------------------------------------------------
//  One-bit full-subtractor cell: d = a - b - bin, bout set when that
//  single-bit difference underflows.
// ----------------------------------------------------------------------------
module subtrator_completo_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

// ----------------------------------------------------------------------------
//  Top level
// ----------------------------------------------------------------------------
module subtrator_completo #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  // Borrow chain: w_borrow[0] is the external borrow-in, w_borrow[i+1] is
  // the borrow out of bit i, so w_borrow[WIDTH] is the final borrow.
  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_diff;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_valid;

  assign w_borrow[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    subtrator_completo_cell u_cell (
      .i_a    (a[i]),
      .i_b    (b[i]),
      .i_bin  (w_borrow[i]),
      .o_d    (w_diff[i]),
      .o_bout (w_borrow[i+1])
    );
  end

  // Result registers only load on qualified cycles, so operand values seen
  // while in_valid is low never reach the outputs. Reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_diff;
        r_cout <= w_borrow[WIDTH];
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_subtrator_completo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_subtrator_completo
//  Description : Self-checking bench for subtrator_completo at WIDTH 1, 4
//                and 8. Expected values come from plain unsigned arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_subtrator_completo;

  logic clk;
  logic rst;

  logic       v1, cin1, c1, ov1;
  logic [0:0] a1, b1, s1;
  logic       v4, cin4, c4, ov4;
  logic [3:0] a4, b4, s4;
  logic       v8, cin8, c8, ov8;
  logic [7:0] a8, b8, s8;

  int errors = 0;
  int checks = 0;

  subtrator_completo #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(c1), .out_valid(ov1)
  );
  subtrator_completo #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(c4), .out_valid(ov4)
  );
  subtrator_completo #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(c8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: difference modulo 2^w and borrow when a < b + cin.
  function automatic logic [63:0] ref_s(int w, logic [63:0] a, logic [63:0] b, logic cin);
    logic [64:0] diff;
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    diff = {1'b0, a} - {1'b0, b} - {64'd0, cin};
    return diff[63:0] & mask;
  endfunction

  function automatic logic ref_c(logic [63:0] a, logic [63:0] b, logic cin);
    return ({1'b0, a} < ({1'b0, b} + {64'd0, cin}));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp8_s;
    logic       exp8_c;
    logic [3:0] ea, eb;

    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    v4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    v8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    #2;
    tick();
    tick();

    // Reset state
    chk("rst_s1", 64'(s1), 0);   chk("rst_c1", 64'(c1), 0);   chk("rst_ov1", 64'(ov1), 0);
    chk("rst_s4", 64'(s4), 0);   chk("rst_c4", 64'(c4), 0);   chk("rst_ov4", 64'(ov4), 0);
    chk("rst_s8", 64'(s8), 0);   chk("rst_c8", 64'(c8), 0);   chk("rst_ov8", 64'(ov8), 0);

    // Operand presented during reset is discarded
    v4 = 1; a4 = 4'h0; b4 = 4'h1; cin4 = 0;
    tick();
    chk("rstprio_s4", 64'(s4), 0);
    chk("rstprio_c4", 64'(c4), 0);
    chk("rstprio_ov4", 64'(ov4), 0);
    v4 = 0;
    rst = 1'b0;

    // WIDTH=1 directed vectors
    v1 = 1; a1 = 1'b0; b1 = 1'b0; cin1 = 0; tick();
    chk("w1_000_s", 64'(s1), 0); chk("w1_000_c", 64'(c1), 0); chk("w1_000_ov", 64'(ov1), 1);
    a1 = 1'b1; b1 = 1'b0; cin1 = 0; tick();
    chk("w1_100_s", 64'(s1), 1); chk("w1_100_c", 64'(c1), 0);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1; tick();
    chk("w1_111_s", 64'(s1), 1); chk("w1_111_c", 64'(c1), 1);
    a1 = 1'b0; b1 = 1'b1; cin1 = 0; tick();
    chk("w1_010_s", 64'(s1), 1); chk("w1_010_c", 64'(c1), 1);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1; tick();
    chk("w1_001_s", 64'(s1), 1); chk("w1_001_c", 64'(c1), 1);

    // WIDTH=1 exhaustive against the arithmetic model, back-to-back
    for (int k = 0; k < 8; k++) begin
      a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = k[0];
      tick();
      chk($sformatf("w1_exh%0d_s", k), 64'(s1), ref_s(1, 64'(k >> 2 & 1), 64'(k >> 1 & 1), k[0]));
      chk($sformatf("w1_exh%0d_c", k), 64'(c1), 64'(ref_c(64'(k >> 2 & 1), 64'(k >> 1 & 1), k[0])));
      chk($sformatf("w1_exh%0d_ov", k), 64'(ov1), 1);
    end
    v1 = 0; tick();
    chk("w1_idle_ov", 64'(ov1), 0);

    // WIDTH=4 directed vectors
    v4 = 1; a4 = 4'h0; b4 = 4'h0; cin4 = 1; tick();
    chk("w4_wrap_s", 64'(s4), 64'hF); chk("w4_wrap_c", 64'(c4), 1); chk("w4_wrap_ov", 64'(ov4), 1);
    a4 = 4'hF; b4 = 4'h0; cin4 = 0; tick();
    chk("w4_max_s", 64'(s4), 64'hF); chk("w4_max_c", 64'(c4), 0);
    a4 = 4'h7; b4 = 4'h7; cin4 = 0; tick();
    chk("w4_eq0_s", 64'(s4), 0); chk("w4_eq0_c", 64'(c4), 0);
    a4 = 4'h7; b4 = 4'h7; cin4 = 1; tick();
    chk("w4_eq1_s", 64'(s4), 64'hF); chk("w4_eq1_c", 64'(c4), 1);
    a4 = 4'h3; b4 = 4'h9; cin4 = 0; tick();
    chk("w4_39_s", 64'(s4), 64'hA); chk("w4_39_c", 64'(c4), 1);
    a4 = 4'h9; b4 = 4'h3; cin4 = 1; tick();
    chk("w4_93_s", 64'(s4), 64'h5); chk("w4_93_c", 64'(c4), 0);

    // Hold: idle cycles with new operands must not disturb the result
    v4 = 0; a4 = 4'hF; b4 = 4'h1; cin4 = 0; tick();
    chk("w4_hold_s", 64'(s4), 64'h5); chk("w4_hold_c", 64'(c4), 0); chk("w4_hold_ov", 64'(ov4), 0);
    a4 = 4'h0; b4 = 4'hF; cin4 = 1; tick();
    chk("w4_hold2_s", 64'(s4), 64'h5); chk("w4_hold2_c", 64'(c4), 0);

    // WIDTH=4 exhaustive sweep with cin alternating
    v4 = 1;
    for (int k = 0; k < 256; k++) begin
      ea = 4'(k >> 4); eb = 4'(k);
      a4 = ea; b4 = eb; cin4 = k[0] ^ k[4];
      tick();
      chk("w4_sweep_s", 64'(s4), ref_s(4, 64'(ea), 64'(eb), k[0] ^ k[4]));
      chk("w4_sweep_c", 64'(c4), 64'(ref_c(64'(ea), 64'(eb), k[0] ^ k[4])));
    end
    v4 = 0;

    // WIDTH=8 randomized stream with occasional idle cycles
    exp8_s = 8'h00;
    exp8_c = 1'b0;
    for (int n = 0; n < 1300; n++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      v8   = ($urandom_range(0, 9) != 0);
      if (v8) begin
        exp8_s = 8'(ref_s(8, 64'(a8), 64'(b8), cin8));
        exp8_c = ref_c(64'(a8), 64'(b8), cin8);
      end
      tick();
      chk("w8_rand_s", 64'(s8), 64'(exp8_s));
      chk("w8_rand_c", 64'(c8), 64'(exp8_c));
      chk("w8_rand_ov", 64'(ov8), 64'(v8));
    end

    // Mid-stream reset with a valid operand present, then recovery
    v8 = 1; a8 = 8'h00; b8 = 8'hFF; cin8 = 1; tick();
    rst = 1'b1; a8 = 8'h55; b8 = 8'hAA; cin8 = 0; tick();
    chk("w8_mrst_s", 64'(s8), 0); chk("w8_mrst_c", 64'(c8), 0); chk("w8_mrst_ov", 64'(ov8), 0);
    rst = 1'b0; a8 = 8'h10; b8 = 8'h01; cin8 = 0; tick();
    chk("w8_after_s", 64'(s8), 64'h0F); chk("w8_after_c", 64'(c8), 0); chk("w8_after_ov", 64'(ov8), 1);
    v8 = 0; tick();
    chk("w8_after_idle_ov", 64'(ov8), 0);
    chk("w8_after_idle_s", 64'(s8), 64'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
